// File: rtl/ripple_add_seq_pkg.sv
// Shared types and helpers for the multi-word ripple add/subtract sequencer.
package ripple_add_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  // Slice index width: $clog2(words), but never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int unsigned DefaultWords = 4;
  localparam int unsigned DefaultIdxW  = idx_width(DefaultWords);

endpackage

// File: rtl/ripple_adder.sv
// N_BITS-wide combinational ripple-carry adder built from a chain of full adders.
module ripple_adder #(
  parameter int unsigned N_BITS = 4
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              cin,
  output logic [N_BITS-1:0] sum,
  output logic              cout
);

  logic [N_BITS:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N_BITS; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N_BITS];

endmodule

// File: rtl/ripple_add_sequencer.sv
// Wide add/subtract performed one N_BITS slice per clock through a single ripple adder,
// least-significant slice first, with the carry registered between slices.
module ripple_add_sequencer
  import ripple_add_seq_pkg::*;
#(
  parameter int unsigned N_BITS = 4,
  parameter int unsigned WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_BITS*WORDS-1:0] a,
  input  logic [N_BITS*WORDS-1:0] b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_BITS*WORDS-1:0] result,
  output logic                    cout,
  output logic                    overflow,
  output logic                    busy
);

  localparam int unsigned W    = N_BITS * WORDS;
  localparam int unsigned IdxW = idx_width(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  seq_state_e      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [N_BITS-1:0] slice_a, slice_b, slice_sum;
  logic              slice_cout;

  assign slice_a = a_q[idx_q*N_BITS +: N_BITS];
  assign slice_b = b_q[idx_q*N_BITS +: N_BITS];

  ripple_adder #(
    .N_BITS(N_BITS)
  ) u_adder (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[idx_q*N_BITS +: N_BITS] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N_BITS-1] != a_q[W-1]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Directed bench for ripple_add_sequencer with N_BITS=4, WORDS=4 (16-bit operands).
module tb_ripple_add_sequencer;

  localparam int unsigned NBits = 4;
  localparam int unsigned Words = 4;
  localparam int unsigned W     = NBits * Words;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ripple_add_sequencer #(
    .N_BITS(NBits),
    .WORDS (Words)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation at a negedge, wait for out_valid and check latency and results.
  // Leaves the DUT in DONE with out_ready low.
  task automatic start_and_wait(input string tag, input logic [W-1:0] op_a,
                                input logic [W-1:0] op_b, input logic op_sub,
                                input logic [W-1:0] exp_res, input logic exp_cout,
                                input logic exp_ovf);
    int cycles;
    @(negedge clk);
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    a = op_a;
    b = op_b;
    sub = op_sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd4);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen_valid;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    start_and_wait("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    release_result("add_basic");
    start_and_wait("add_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    release_result("add_carry");
    start_and_wait("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    release_result("sub_ovf");
    start_and_wait("sub_borrow", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    release_result("sub_borrow");
    start_and_wait("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    release_result("add_ovf");

    // Backpressure: hold DONE while new operands are offered.
    start_and_wait("bp", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 16'hAAAA + 16'(i);
      b = 16'h1111;
      sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_result", 32'(result), 32'h0100);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_result("bp");
    start_and_wait("bp_fresh", 16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1);
    release_result("bp_fresh");

    // Reset mid-RUN with idx == 2.
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", 32'(result), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    check("abort_no_out_valid", 32'(seen_valid), 32'd0);
    start_and_wait("post_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    release_result("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_add_sequencer.md
# ripple_add_sequencer

Multi-word add/subtract controller that sequences a single N_BITS `ripple_adder` over WORDS slices of wide operands, one slice per clock, least-significant slice first. The carry is registered between slices. Operands enter and results leave through valid/ready handshakes. It sits between a wide-operand producer and consumer wherever a full-width combinational adder is too large or too slow.

## Interface
- N_BITS, 4: slice width; the width of the instantiated `ripple_adder` (must be ≥ 2).
- WORDS, 4: number of slices (≥ 1); operand width W = N_BITS*WORDS.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1 = A−B, 0 = A+B; sampled with the operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference, modulo 2^W.
- cout  out  1  final carry out (for sub: 1 = no borrow).
- overflow  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge:
  - latch a into a_q;
  - latch b into b_q, or ~b if sub=1;
  - set carry_q = sub;
  - set idx = 0;
  - go to RUN.
- RUN, each edge:
  - drive the adder with a_q[idx*N_BITS +: N_BITS], b_q[same slice] and carry_q;
  - write the adder sum into result[same slice];
  - load the adder cout into carry_q;
  - if idx == WORDS−1: register cout, compute overflow and go to DONE; otherwise increment idx.
- Overflow rule: overflow = (a_q[W−1] == b_q[W−1]) && (sum MSB != a_q[W−1]), using the inverted B when sub=1.
- DONE: out_valid=1. result, cout and overflow are held stable. On an edge with out_ready=1, go to IDLE.
- Outputs persist in IDLE and are overwritten slice by slice in the next RUN. They are only meaningful while out_valid=1.
- in_valid is ignored outside IDLE; no queuing.
- WORDS=1: RUN lasts exactly one cycle.
- rst=1 at any edge, including mid-RUN or during DONE:
  - state ← IDLE, idx ← 0, carry_q ← 0;
  - result, cout and overflow ← 0;
  - any in-flight operation is discarded with no out_valid pulse.

## Timing
- Reset values (after the rst edge): in_ready=1, out_valid=0, busy=0, result=0, cout=0, overflow=0.
- Accept edge E0 (in_valid & in_ready). Slice k is written at edge E(k+1).
- out_valid rises after edge E_WORDS, so latency is WORDS cycles from accept to out_valid.
- Minimum occupancy per operation is WORDS+1 cycles (RUN plus one DONE cycle). in_ready rises the cycle after the out_ready handshake, giving a peak throughput of one operation per WORDS+2 cycles.
- out_valid, in_ready and busy are decoded from registered state; there are no combinational paths from in_valid or out_ready to any output.
- The adder path is combinational within one cycle: slice mux, then N_BITS ripple, then register.

## Structure
- Package `ripple_add_seq_pkg`:
  - typedef enum for state {IDLE, RUN, DONE};
  - localparam for the index width $clog2(WORDS), minimum 1.
- One sub-module: the existing `ripple_adder #(.N_BITS(N_BITS))`, instantiated once. No other hierarchy.

## Test plan
All scenarios use N_BITS=4, WORDS=4.
1. Add 0x1234 + 0x0FFF, sub=0 → result=0x2233, cout=0, overflow=0; out_valid exactly 4 cycles after accept.
2. Add 0xFFFF + 0x0001 → result=0x0000, cout=1, overflow=0; the carry propagates through all 4 slices.
3. Subtract 0x8000 − 0x0001 → result=0x7FFF, cout=1, overflow=1. Subtract 0x0001 − 0x0002 → result=0xFFFF, cout=0, overflow=0.
4. Add 0x7FFF + 0x0001 → result=0x8000, overflow=1, cout=0.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands → result stable, in_ready=0, new operands ignored. out_ready=1 → IDLE next cycle, then a fresh operation completes correctly.
6. Assert rst for one cycle while idx=2 in RUN → next cycle state IDLE, result=0, out_valid never asserted. A following 0x0003 + 0x0004 → result=0x0007.
